// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcode encodings, default
// widths and the sequencer state encoding.
package alu_pkg;

   localparam int ALU_WIDTH = 8;
   localparam int ALU_SEL_W = 4;
   localparam int ALU_CNT_W = 16;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_DIV  = 4'd3;
   localparam logic [3:0] OP_SHL  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_ROL  = 4'd6;
   localparam logic [3:0] OP_ROR  = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_NOR  = 4'd11;
   localparam logic [3:0] OP_NAND = 4'd12;
   localparam logic [3:0] OP_XNOR = 4'd13;
   localparam logic [3:0] OP_GT   = 4'd14;
   localparam logic [3:0] OP_EQ   = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshakes between a command source/result consumer
// (master) and the ALU command sequencer (slave).
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 4
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [SEL_W-1:0] cmd_sel;
   logic             cmd_chain;

   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_carry;
   logic             res_zero;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain, res_ready,
      input  cmd_ready, res_valid, res_data, res_carry, res_zero
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_chain, res_ready,
      output cmd_ready, res_valid, res_data, res_carry, res_zero
   );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Upstream command stage for the combinational alu. Registers one command
// onto the alu inputs, captures the result a cycle later and holds it for
// the consumer. Chaining feeds the last captured result back as operand A.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | cmd_ready=1, waiting for a command; loads alu inputs
//   ST_EXEC | alu settling; result, carry and acc captured at cycle end
//   ST_DONE | res_valid=1, result held until res_ready; counts delivery
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int SEL_W = ALU_SEL_W,
   parameter int CNT_W = ALU_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst,
   alu_cmd_sequencer_if.slave     bus,
   output logic [WIDTH-1:0]       alu_a,
   output logic [WIDTH-1:0]       alu_b,
   output logic [SEL_W-1:0]       alu_sel,
   input  logic [WIDTH-1:0]       alu_out,
   input  logic                   alu_carry,
   output logic                   busy,
   output logic [CNT_W-1:0]       op_count
);

   seq_state_t       state;
   seq_state_t       state_nxt;
   logic             load_cmd;
   logic             capture;
   logic             deliver;
   logic             cmd_ready_c;
   logic             res_valid_c;
   logic [WIDTH-1:0] res_data_q;
   logic             res_carry_q;
   logic [WIDTH-1:0] acc;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next state and handshake outputs; both handshakes depend on state only.
   always_comb begin
      state_nxt   = state;
      cmd_ready_c = 1'b0;
      res_valid_c = 1'b0;
      load_cmd    = 1'b0;
      capture     = 1'b0;
      deliver     = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready_c = 1'b1;
            if (bus.cmd_valid) begin
               load_cmd  = 1'b1;
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            capture   = 1'b1;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            res_valid_c = 1'b1;
            if (bus.res_ready) begin
               deliver   = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Alu input registers; they keep the last command after completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
      end else if (load_cmd) begin
         alu_a   <= bus.cmd_chain ? acc : bus.cmd_a;
         alu_b   <= bus.cmd_b;
         alu_sel <= bus.cmd_sel;
      end
   end

   // Result capture and accumulator, written only at the end of EXEC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_data_q  <= '0;
         res_carry_q <= 1'b0;
         acc         <= '0;
      end else if (capture) begin
         res_data_q  <= alu_out;
         res_carry_q <= alu_carry;
         acc         <= alu_out;
      end
   end

   // Delivered-result counter, saturating at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (deliver && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.res_valid = res_valid_c;
   assign bus.res_data  = res_data_q;
   assign bus.res_carry = res_carry_q;
   assign bus.res_zero  = (res_data_q == '0);
   assign busy          = (state != ST_IDLE);

endmodule
